// File: rtl/rv32i_pkg.sv
// RV32I opcode constants, operation classes and immediate formats shared by
// the instruction queue/decoder.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_OPIMM,
    CLS_OP,
    CLS_FENCE,
    CLS_SYSTEM
  } op_class_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  function automatic imm_fmt_t imm_fmt_of(op_class_t cls);
    case (cls)
      CLS_JALR, CLS_LOAD, CLS_OPIMM, CLS_SYSTEM: imm_fmt_of = IMM_I;
      CLS_STORE:                                 imm_fmt_of = IMM_S;
      CLS_BRANCH:                                imm_fmt_of = IMM_B;
      CLS_LUI, CLS_AUIPC:                        imm_fmt_of = IMM_U;
      CLS_JAL:                                   imm_fmt_of = IMM_J;
      default:                                   imm_fmt_of = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/inst_queue_decode_if.sv
// Fetch-side push handshake, flush and decoded-head valid/ready bundle.
interface inst_queue_decode_if;
  import rv32i_pkg::*;

  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_vacant;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  op_class_t   dec_class;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [2:0]  dec_funct3;
  logic        dec_funct7b5;
  logic [31:0] dec_imm;
  logic [31:0] dec_inst;

  modport master (
    output inst_valid, inst, flush, dec_ready,
    input  inst_vacant, dec_valid, dec_class, dec_rd, dec_rs1, dec_rs2,
           dec_funct3, dec_funct7b5, dec_imm, dec_inst
  );

  modport slave (
    input  inst_valid, inst, flush, dec_ready,
    output inst_vacant, dec_valid, dec_class, dec_rd, dec_rs1, dec_rs2,
           dec_funct3, dec_funct7b5, dec_imm, dec_inst
  );

endinterface

// File: rtl/inst_fifo.sv
// DEPTH x WIDTH instruction storage with wrapping pointers and an occupancy
// count; push/pop arrive already qualified, flush clears everything.
module inst_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_queue_decode.sv
// Buffers fetched RV32I words and decodes the queue head into register
// fields, immediate and operation class behind a valid/ready handshake.
module inst_queue_decode
  import rv32i_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic                clk,
  input logic                rst,
  inst_queue_decode_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]         count;
  logic [INST_WIDTH-1:0] head;
  logic                  vacant;
  logic                  not_empty;
  logic                  push;
  logic                  pop;
  op_class_t             cls;
  logic [31:0]           imm;

  // Vacancy looks only at the registered count, so a full queue stays
  // closed even in a cycle where the head is being consumed.
  assign vacant    = (count != CW'(DEPTH));
  assign not_empty = (count != '0);
  assign push      = bus.inst_valid & vacant & ~bus.flush;
  assign pop       = not_empty & bus.dec_ready & ~bus.flush;

  inst_fifo #(
    .WIDTH (INST_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .wdata (bus.inst),
    .head  (head),
    .count (count)
  );

  always_comb begin
    cls = CLS_ILLEGAL;
    if (head[1:0] == 2'b11) begin
      case (head[6:0])
        OPC_LUI:    cls = CLS_LUI;
        OPC_AUIPC:  cls = CLS_AUIPC;
        OPC_JAL:    cls = CLS_JAL;
        OPC_JALR:   cls = CLS_JALR;
        OPC_BRANCH: cls = CLS_BRANCH;
        OPC_LOAD:   cls = CLS_LOAD;
        OPC_STORE:  cls = CLS_STORE;
        OPC_OPIMM:  cls = CLS_OPIMM;
        OPC_OP:     cls = CLS_OP;
        OPC_FENCE:  cls = CLS_FENCE;
        OPC_SYSTEM: cls = CLS_SYSTEM;
        default:    cls = CLS_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    imm = '0;
    case (imm_fmt_of(cls))
      IMM_I:   imm = {{20{head[31]}}, head[31:20]};
      IMM_S:   imm = {{20{head[31]}}, head[31:25], head[11:7]};
      IMM_B:   imm = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
      IMM_U:   imm = {head[31:12], 12'b0};
      IMM_J:   imm = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // An empty queue presents an all-zero decode so stale storage never leaks.
  always_comb begin
    bus.dec_class    = CLS_ILLEGAL;
    bus.dec_rd       = '0;
    bus.dec_rs1      = '0;
    bus.dec_rs2      = '0;
    bus.dec_funct3   = '0;
    bus.dec_funct7b5 = 1'b0;
    bus.dec_imm      = '0;
    bus.dec_inst     = '0;
    if (not_empty) begin
      bus.dec_class    = cls;
      bus.dec_rd       = head[11:7];
      bus.dec_rs1      = head[19:15];
      bus.dec_rs2      = head[24:20];
      bus.dec_funct3   = head[14:12];
      bus.dec_funct7b5 = head[30];
      bus.dec_imm      = imm;
      bus.dec_inst     = head;
    end
  end

  assign bus.inst_vacant = vacant;
  assign bus.dec_valid   = not_empty;

endmodule

// File: tb/tb_inst_queue_decode.sv
// Directed bench for inst_queue_decode: table of decode vectors plus
// hand-written fill, flush, full-with-pop and async-reset sequences.
module tb_inst_queue_decode;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[16];

  inst_queue_decode_if bus ();

  inst_queue_decode #(
    .INST_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] decBus();
    return {41'd0, 4'(bus.dec_class), bus.dec_rd, bus.dec_rs1, bus.dec_rs2,
            bus.dec_funct3, bus.dec_funct7b5, bus.dec_imm, bus.dec_inst};
  endfunction

  function automatic logic [127:0] decExp(vec_t v);
    return {41'd0, v.cls, v.rd, v.rs1, v.rs2, v.f3, v.f7, v.imm, v.word};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives inputs at a falling edge, lets one rising edge pass, returns at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    bus.inst_valid = v;
    bus.inst       = w;
    bus.dec_ready  = rdy;
    bus.flush      = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] fill_words[4];
    checks = 0;
    errors = 0;

    vecs[0]  = '{32'h00500093, 4'd8,  5'd1,  5'd0,  5'd5,  3'd0, 1'b0, 32'h00000005};
    vecs[1]  = '{32'h123452B7, 4'd1,  5'd5,  5'd8,  5'd3,  3'd5, 1'b0, 32'h12345000};
    vecs[2]  = '{32'hFE000EE3, 4'd5,  5'd29, 5'd0,  5'd0,  3'd0, 1'b1, 32'hFFFFFFFC};
    vecs[3]  = '{32'h0080A103, 4'd6,  5'd2,  5'd1,  5'd8,  3'd2, 1'b0, 32'h00000008};
    vecs[4]  = '{32'h0080006F, 4'd3,  5'd0,  5'd0,  5'd8,  3'd0, 1'b0, 32'h00000008};
    vecs[5]  = '{32'hFFDFF0EF, 4'd3,  5'd1,  5'd31, 5'd29, 3'd7, 1'b1, 32'hFFFFFFFC};
    vecs[6]  = '{32'hFE112E23, 4'd7,  5'd28, 5'd2,  5'd1,  3'd2, 1'b1, 32'hFFFFFFFC};
    vecs[7]  = '{32'hFFFFF197, 4'd2,  5'd3,  5'd31, 5'd31, 3'd7, 1'b1, 32'hFFFFF000};
    vecs[8]  = '{32'h000080E7, 4'd4,  5'd1,  5'd1,  5'd0,  3'd0, 1'b0, 32'h00000000};
    vecs[9]  = '{32'h00000073, 4'd11, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000};
    vecs[10] = '{32'h40B50533, 4'd9,  5'd10, 5'd10, 5'd11, 3'd0, 1'b1, 32'h00000000};
    vecs[11] = '{32'h0FF0000F, 4'd10, 5'd0,  5'd0,  5'd31, 3'd0, 1'b0, 32'h00000000};
    vecs[12] = '{32'h00000000, 4'd0,  5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000};
    vecs[13] = '{32'h00500091, 4'd0,  5'd1,  5'd0,  5'd5,  3'd0, 1'b0, 32'h00000000};
    vecs[14] = '{32'h0000007F, 4'd0,  5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000};
    vecs[15] = '{32'hFFF00093, 4'd8,  5'd1,  5'd0,  5'd31, 3'd0, 1'b1, 32'hFFFFFFFF};

    fill_words[0] = 32'h11111113;
    fill_words[1] = 32'h22222223;
    fill_words[2] = 32'h33333333;
    fill_words[3] = 32'h44444443;

    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    bus.dec_ready  = 1'b0;
    bus.flush      = 1'b0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_vacant", 128'(bus.inst_vacant), 128'd1);
    checkOutput("reset_valid",  128'(bus.dec_valid),   128'd0);
    checkOutput("reset_imm",    128'(bus.dec_imm),     128'd0);
    checkOutput("reset_decode", decBus(),              128'd0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, vecs[i].word, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d_valid", i), 128'(bus.dec_valid), 128'd1);
      checkOutput($sformatf("vec%0d_decode", i), decBus(), decExp(vecs[i]));
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput($sformatf("vec%0d_popped", i), 128'(bus.dec_valid), 128'd0);
      checkOutput($sformatf("vec%0d_zeroed", i), decBus(), 128'd0);
    end

    // Fill to full, attempt a fifth push, then drain in order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fill_words[i], 1'b0, 1'b0);
      checkOutput($sformatf("fill%0d_vacant", i), 128'(bus.inst_vacant), (i == 3) ? 128'd0 : 128'd1);
    end
    applyStimulus(1'b1, 32'h55555553, 1'b0, 1'b0);
    checkOutput("full_still_closed", 128'(bus.inst_vacant), 128'd0);
    checkOutput("full_head_stable",  128'(bus.dec_inst),    128'(fill_words[0]));
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d_head", i), 128'(bus.dec_inst), 128'(fill_words[i]));
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 128'(bus.dec_valid), 128'd0);

    // Flush with a push and a pop request in the same cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, fill_words[i], 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h66666663, 1'b1, 1'b1);
    checkOutput("flush_valid",  128'(bus.dec_valid),   128'd0);
    checkOutput("flush_vacant", 128'(bus.inst_vacant), 128'd1);
    checkOutput("flush_decode", decBus(),              128'd0);
    applyStimulus(1'b1, vecs[0].word, 1'b0, 1'b0);
    checkOutput("post_flush_valid",  128'(bus.dec_valid), 128'd1);
    checkOutput("post_flush_decode", decBus(),            decExp(vecs[0]));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("post_flush_single", 128'(bus.dec_valid), 128'd0);

    // Full queue with pop and push together: only the pop happens.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, fill_words[i], 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h77777773, 1'b1, 1'b0);
    checkOutput("fullpop_vacant", 128'(bus.inst_vacant), 128'd1);
    checkOutput("fullpop_head",   128'(bus.dec_inst),    128'(fill_words[1]));
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("fullpop_drain%0d", i), 128'(bus.dec_inst), 128'(fill_words[i]));
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("fullpop_count3", 128'(bus.dec_valid), 128'd0);

    // Back-to-back push and pop with dec_ready held high.
    applyStimulus(1'b1, vecs[1].word, 1'b1, 1'b0);
    checkOutput("stream0", decBus(), decExp(vecs[1]));
    applyStimulus(1'b1, vecs[3].word, 1'b1, 1'b0);
    checkOutput("stream1", decBus(), decExp(vecs[3]));
    applyStimulus(1'b1, vecs[2].word, 1'b1, 1'b0);
    checkOutput("stream2", decBus(), decExp(vecs[2]));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("stream_empty", 128'(bus.dec_valid), 128'd0);

    // Asynchronous reset between clock edges.
    applyStimulus(1'b1, fill_words[0], 1'b0, 1'b0);
    applyStimulus(1'b1, fill_words[1], 1'b0, 1'b0);
    bus.inst_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid",  128'(bus.dec_valid),   128'd0);
    checkOutput("async_rst_vacant", 128'(bus.inst_vacant), 128'd1);
    checkOutput("async_rst_decode", decBus(),              128'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, vecs[6].word, 1'b0, 1'b0);
    checkOutput("after_rst_decode", decBus(), decExp(vecs[6]));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("after_rst_single", 128'(bus.dec_valid), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue_decode.md
# inst_queue_decode

Instruction-side consumer of the fetch unit's `inst_valid`/`inst`/`inst_vacant` handshake. It supplies the `id_to_if_vacant` signal that is currently tied high in the top level. The block buffers fetched RV32I words in a small FIFO and decodes the head entry into register indices, sign-extended immediate and an operation class. It presents the result to the downstream issue logic through a valid/ready handshake, and supports a whole-queue flush on a PC redirect.

## Interface
- `INST_WIDTH`, default 32: instruction width; only 32 is supported.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and ≥2.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `inst_valid` input, 1: fetch presents `inst` this cycle.
- `inst` input, 32: fetched instruction word.
- `inst_vacant` output, 1: queue can accept a word this cycle.
- `flush` input, 1: redirect; drop all queued and incoming words. Driven by the writeback `offset_valid`.
- `dec_valid` output, 1: head entry is decoded and available.
- `dec_ready` input, 1: downstream consumes the head this cycle.
- `dec_class` output, 4: operation class (package enum).
- `dec_rd`, `dec_rs1`, `dec_rs2` output, 5 each: register fields.
- `dec_funct3` output, 3: `inst[14:12]`.
- `dec_funct7b5` output, 1: `inst[30]`.
- `dec_imm` output, 32: sign-extended immediate for the class.
- `dec_inst` output, 32: raw head word.

## Operation
- **Push:** occurs when `inst_valid & inst_vacant & ~flush`. The word is written at the write pointer.
- **Pop:** occurs when `dec_valid & dec_ready & ~flush`. The read pointer advances.
- **Vacancy:** `inst_vacant = (count != DEPTH)`, combinational from registered count only. There is no full-bypass: when full, vacant stays low even if a pop occurs in the same cycle.
- **Push and pop together:** count unchanged; both pointers advance.
- **Flush:** highest priority. On the next edge, count and both pointers become 0. A push in the flush cycle is discarded and a pop is not counted.
- **Pointer width:** pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- **Decode (combinational on the head entry):**
  - Low bits: if `inst[1:0] != 2'b11`, the class is ILLEGAL.
  - Opcode to class: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OPIMM, 0110011 OP, 0001111 FENCE, 1110011 SYSTEM. Any other opcode is ILLEGAL.
  - Immediate format by class:
    - I: JALR, LOAD, OPIMM, SYSTEM.
    - S: STORE.
    - B: BRANCH, with bit 0 = 0.
    - U: LUI, AUIPC; `{inst[31:12], 12'b0}`.
    - J: JAL, with bit 0 = 0.
    - Others: 0.
  - Sign bit is always `inst[31]`.
- **Empty queue:** when `dec_valid=0`, all `dec_*` outputs are forced to 0. `dec_class` is then ILLEGAL (encoding 0).
- **Illegal words:** ILLEGAL entries still assert `dec_valid`. Exception handling is downstream.

## Timing
- **Reset values:** `inst_vacant=1`, `dec_valid=0`, all `dec_*` = 0. Count and pointers are 0; storage is cleared.
- **Latency:** a word pushed at edge N produces `dec_valid=1` with its decode in the cycle after edge N, provided it becomes the head.
- **Throughput:** one push and one pop per cycle.
- **Recovery from flush:**
  - A flush asserted in cycle C makes `dec_valid=0` and `inst_vacant=1` from edge C onward.
  - A push in cycle C+1 is accepted normally.
- **Reset mid-operation:** reset immediately returns all state to reset values, regardless of the clock.
- **Downstream handshake:** the downstream may hold `dec_ready` high continuously. The outputs are stable while `dec_valid & ~dec_ready`.

## Structure
- **Package `rv32i_pkg`:**
  - 7-bit opcode constants.
  - `op_class_t` 4-bit enum: ILLEGAL=0, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM.
  - Immediate-format enum.
- **Sub-module `inst_fifo`:** parameterised DEPTH×32 storage plus pointers and count. It takes push/pop/flush inputs and provides head/count outputs.
- **Decode:** the decode logic lives in the `inst_queue_decode` body.

## Test plan
- **Reset:** hold `rst` for 3 cycles, then release → `inst_vacant=1`, `dec_valid=0`, `dec_imm=0`.
- **Fill to full:** with `dec_ready=0`, push 4 words → `inst_vacant=0` after the 4th push edge. A 5th `inst_valid` is not accepted. Raising `dec_ready` pops the words in push order.
- **I and U decode:**
  - Push 0x00500093 → OPIMM, rd=1, rs1=0, imm=5.
  - Push 0x123452B7 → LUI, rd=5, imm=0x12345000.
- **Branch and load decode:**
  - Push 0xFE000EE3 → BRANCH, funct3=0, imm=0xFFFFFFFC.
  - Push 0x0080A103 → LOAD, rd=2, rs1=1, funct3=2, imm=8.
- **Flush with push:** queue holds 3 words; assert `flush` with `inst_valid=1` → next cycle count=0, `dec_valid=0`, and the incoming word is lost.
- **Full with pop, then illegal:**
  - When full, assert pop and push in the same cycle → pop occurs, no push, count=3.
  - Push 0x00000000 → `dec_valid=1`, class ILLEGAL.
